// File: rtl/dcmac_seq_pkg.sv
// Shared types and constants for the DCMAC link bring-up sequencer.
package dcmac_seq_pkg;

    localparam int NUM_PORTS = 2;
    localparam int TIMER_W   = 32;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PWR_WAIT   = 3'd1,
        RST_ALL    = 3'd2,
        TX_WAIT    = 3'd3,
        RX_WAIT    = 3'd4,
        ALIGN_WAIT = 3'd5,
        RUN        = 3'd6,
        FAULT      = 3'd7
    } main_state_e;

    typedef enum logic [1:0] {
        P_WAIT = 2'd0,
        P_RST  = 2'd1,
        P_UP   = 2'd2,
        P_FAIL = 2'd3
    } port_state_e;

    function automatic logic link_phase(input main_state_e s);
        return (s == ALIGN_WAIT) || (s == RUN);
    endfunction

endpackage

// File: rtl/dcmac_port_recovery.sv
// Per-port RX alignment watchdog: bounded RX datapath resets,
// then a sticky failure until the main sequencer clears it.
module dcmac_port_recovery
    import dcmac_seq_pkg::*;
#(
    parameter int unsigned ALIGN_TIMEOUT = 2**22,
    parameter int unsigned RX_RST_CYCLES = 64,
    parameter int unsigned MAX_RETRY     = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic rx_aligned,
    input  logic rx_reset_done,
    output logic rx_rst,
    output logic up,
    output logic fail,
    output logic rst_issued
);

    localparam logic [TIMER_W-1:0] ALIGN_LAST =
        TIMER_W'(ALIGN_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] RST_LAST =
        TIMER_W'(RX_RST_CYCLES - 1);
    localparam logic [7:0] RETRY_MAX = 8'(MAX_RETRY);

    port_state_e        st;
    port_state_e        nxt;
    logic [TIMER_W-1:0] timer;
    logic [7:0]         retries;
    logic [7:0]         retries_nxt;
    logic               link_ok;

    assign link_ok = rx_aligned && rx_reset_done;

    always_comb begin
        nxt         = st;
        retries_nxt = retries;
        rst_issued  = 1'b0;
        if (!active) begin
            nxt         = P_WAIT;
            retries_nxt = '0;
        end else begin
            unique case (st)
                P_WAIT: begin
                    // Alignment beats a timeout landing on the same cycle.
                    if (link_ok) begin
                        nxt = P_UP;
                    end else if (timer == ALIGN_LAST) begin
                        if (retries == RETRY_MAX) begin
                            nxt = P_FAIL;
                        end else begin
                            nxt         = P_RST;
                            retries_nxt = retries + 8'd1;
                            rst_issued  = 1'b1;
                        end
                    end
                end
                P_RST: begin
                    if (timer == RST_LAST) nxt = P_WAIT;
                end
                P_UP: begin
                    retries_nxt = '0;
                    if (!link_ok) nxt = P_WAIT;
                end
                P_FAIL: begin
                    nxt = P_FAIL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st      <= P_WAIT;
            timer   <= '0;
            retries <= '0;
            rx_rst  <= 1'b0;
            up      <= 1'b0;
            fail    <= 1'b0;
        end else begin
            st      <= nxt;
            retries <= retries_nxt;
            if (!active || nxt != st) timer <= '0;
            else                      timer <= timer + TIMER_W'(1);
            rx_rst  <= (nxt == P_RST);
            up      <= (nxt == P_UP);
            fail    <= (nxt == P_FAIL);
        end
    end

endmodule

// File: rtl/dcmac_link_sequencer.sv
// Bring-up and recovery sequencer for the two-port DCMAC/GT helper
// reset inputs; runs entirely in the s_axi_clk domain.
module dcmac_link_sequencer
    import dcmac_seq_pkg::*;
#(
    parameter int unsigned RESET_CYCLES  = 256,
    parameter int unsigned DONE_TIMEOUT  = 2**20,
    parameter int unsigned ALIGN_TIMEOUT = 2**22,
    parameter int unsigned RX_RST_CYCLES = 64,
    parameter int unsigned MAX_RETRY     = 7
) (
    input  logic                 s_axi_clk,
    input  logic                 s_axi_reset,
    input  logic                 enable,
    input  logic                 gtpowergood,
    input  logic [NUM_PORTS-1:0] gt_tx_reset_done,
    input  logic [NUM_PORTS-1:0] gt_rx_reset_done,
    input  logic [NUM_PORTS-1:0] rx_aligned,
    output logic                 user_gt_reset_all,
    output logic [NUM_PORTS-1:0] user_gt_reset_rx_datapath,
    output logic [NUM_PORTS-1:0] link_up,
    output logic                 fault,
    output logic [2:0]           state,
    output logic [7:0]           retry_count
);

    localparam logic [TIMER_W-1:0] RST_LAST =
        TIMER_W'(RESET_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DONE_LAST =
        TIMER_W'(DONE_TIMEOUT - 1);

    main_state_e          st;
    main_state_e          nxt;
    logic [TIMER_W-1:0]   timer;
    logic                 restart;
    logic                 port_active;
    logic [NUM_PORTS-1:0] port_up;
    logic [NUM_PORTS-1:0] port_fail;
    logic [NUM_PORTS-1:0] rst_issued;
    logic [9:0]           retry_sum;

    assign state   = st;
    assign link_up = port_up;

    // Ports clear on the same edge the main FSM leaves the link phases,
    // so an RX reset can never overlap user_gt_reset_all.
    assign port_active = link_phase(st) && link_phase(nxt);

    always_comb begin
        nxt     = st;
        restart = 1'b0;
        unique case (st)
            IDLE: begin
                if (enable) nxt = PWR_WAIT;
            end
            PWR_WAIT: begin
                if (gtpowergood) nxt = RST_ALL;
            end
            RST_ALL: begin
                if (timer == RST_LAST) nxt = TX_WAIT;
            end
            TX_WAIT: begin
                if (&gt_tx_reset_done) begin
                    nxt = RX_WAIT;
                end else if (timer == DONE_LAST) begin
                    nxt     = RST_ALL;
                    restart = 1'b1;
                end
            end
            RX_WAIT: begin
                if (&gt_rx_reset_done) begin
                    nxt = ALIGN_WAIT;
                end else if (timer == DONE_LAST) begin
                    nxt     = RST_ALL;
                    restart = 1'b1;
                end
            end
            ALIGN_WAIT: begin
                if (|port_fail)    nxt = FAULT;
                else if (&port_up) nxt = RUN;
            end
            RUN: begin
                if (|port_fail) nxt = FAULT;
            end
            FAULT: begin
                nxt = FAULT;
            end
        endcase

        // Overrides, lowest priority first; FAULT stays latched.
        if (link_phase(st) && !(&gt_tx_reset_done)) begin
            nxt     = RST_ALL;
            restart = 1'b0;
        end
        if (st inside {RST_ALL, TX_WAIT, RX_WAIT, ALIGN_WAIT, RUN}
            && !gtpowergood) begin
            nxt     = PWR_WAIT;
            restart = 1'b0;
        end
        if (!enable) begin
            nxt     = IDLE;
            restart = 1'b0;
        end
    end

    always_comb begin
        retry_sum = 10'(retry_count) + 10'(restart);
        for (int p = 0; p < NUM_PORTS; p++) begin
            retry_sum = retry_sum + 10'(rst_issued[p]);
        end
    end

    always_ff @(posedge s_axi_clk) begin
        if (s_axi_reset) begin
            st                <= IDLE;
            timer             <= '0;
            retry_count       <= '0;
            user_gt_reset_all <= 1'b1;
            fault             <= 1'b0;
        end else begin
            st <= nxt;
            if (nxt != st) timer <= '0;
            else           timer <= timer + TIMER_W'(1);
            if (st == IDLE && nxt != IDLE) retry_count <= '0;
            else if (retry_sum > 10'd255)  retry_count <= 8'hFF;
            else                           retry_count <= retry_sum[7:0];
            user_gt_reset_all <=
                nxt inside {IDLE, PWR_WAIT, RST_ALL, FAULT};
            fault <= (nxt == FAULT);
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        dcmac_port_recovery #(
            .ALIGN_TIMEOUT (ALIGN_TIMEOUT),
            .RX_RST_CYCLES (RX_RST_CYCLES),
            .MAX_RETRY     (MAX_RETRY)
        ) u_port (
            .clk           (s_axi_clk),
            .reset         (s_axi_reset),
            .active        (port_active),
            .rx_aligned    (rx_aligned[p]),
            .rx_reset_done (gt_rx_reset_done[p]),
            .rx_rst        (user_gt_reset_rx_datapath[p]),
            .up            (port_up[p]),
            .fail          (port_fail[p]),
            .rst_issued    (rst_issued[p])
        );
    end

endmodule

// File: tb/tb_dcmac_link_sequencer.sv
// Scoreboard bench: stimulus queues the expected output changes with
// their cycle stamps; the monitor checks every observed change.
module tb_dcmac_link_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       pg = 1'b0;
    logic [1:0] txd = 2'b00;
    logic [1:0] rxd = 2'b00;
    logic [1:0] al = 2'b00;
    logic       ra;
    logic [1:0] rxdp;
    logic [1:0] lu;
    logic       flt;
    logic [2:0] st;
    logic [7:0] rc;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dcmac_link_sequencer #(
        .RESET_CYCLES  (4),
        .DONE_TIMEOUT  (16),
        .ALIGN_TIMEOUT (8),
        .RX_RST_CYCLES (3),
        .MAX_RETRY     (2)
    ) dut (
        .s_axi_clk                 (clk),
        .s_axi_reset               (rst),
        .enable                    (enable),
        .gtpowergood               (pg),
        .gt_tx_reset_done          (txd),
        .gt_rx_reset_done          (rxd),
        .rx_aligned                (al),
        .user_gt_reset_all         (ra),
        .user_gt_reset_rx_datapath (rxdp),
        .link_up                   (lu),
        .fault                     (flt),
        .state                     (st),
        .retry_count               (rc)
    );

    typedef struct packed {
        logic [2:0] s;
        logic       ra;
        logic [1:0] rxd;
        logic [1:0] lu;
        logic       f;
        logic [7:0] rc;
    } obs_t;

    typedef struct {
        int    cyc;
        string nm;
        obs_t  o;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    obs_t prev = 'x;

    task automatic ex(input int c, input string nm,
                      input logic [2:0] s, input logic a,
                      input logic [1:0] d, input logic [1:0] l,
                      input logic f, input logic [7:0] r);
        exp_t e;
        e.cyc = c;
        e.nm  = nm;
        e.o   = {s, a, d, l, f, r};
        q.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] sat(input int n);
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    always @(negedge clk) begin
        obs_t cur;
        exp_t e;
        cur = {st, ra, rxdp, lu, flt, rc};
        if (cur !== prev) begin
            prev = cur;
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected: cycle %0d got %h", cyc, cur);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.o !== cur) begin
                    fails++;
                    $display("FAIL %s: got cycle %0d obs %h, want cycle %0d obs %h",
                             e.nm, cyc, cur, e.cyc, e.o);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: cycle %0d", cyc);
        $fatal(1);
    end

    localparam int N = 258;

    initial begin
        ex(1, "reset", 0, 1, 0, 0, 0, 0);
        goto(2);
        rst = 1'b0;

        // Clean bring-up
        ex(4,  "pwr_wait",   1, 1, 0, 0, 0, 0);
        ex(5,  "rst_all",    2, 1, 0, 0, 0, 0);
        ex(9,  "tx_wait",    3, 0, 0, 0, 0, 0);
        ex(14, "rx_wait",    4, 0, 0, 0, 0, 0);
        ex(15, "align_wait", 5, 0, 0, 0, 0, 0);
        ex(17, "link_up",    5, 0, 0, 3, 0, 0);
        ex(18, "run",        6, 0, 0, 3, 0, 0);
        goto(3);
        enable = 1'b1;
        pg     = 1'b1;
        goto(13);
        txd = 2'b11;
        rxd = 2'b11;
        goto(16);
        al = 2'b11;

        // Port 0 loses alignment for 5 cycles in RUN
        ex(21, "align_loss", 6, 0, 0, 2'b10, 0, 0);
        ex(26, "align_back", 6, 0, 0, 2'b11, 0, 0);
        goto(20);
        al = 2'b10;
        goto(25);
        al = 2'b11;

        // Power-good drop in RUN
        ex(31, "pg_drop", 1, 1, 0, 0, 0, 0);
        goto(30);
        pg = 1'b0;

        // Port 1 never aligns
        ex(34, "rst_all2",    2, 1, 0,     0, 0, 0);
        ex(38, "tx_wait2",    3, 0, 0,     0, 0, 0);
        ex(39, "rx_wait2",    4, 0, 0,     0, 0, 0);
        ex(40, "align2",      5, 0, 0,     0, 0, 0);
        ex(41, "up0",         5, 0, 0,     1, 0, 0);
        ex(48, "rxrst_a",     5, 0, 2'b10, 1, 0, 1);
        ex(51, "rxrst_a_end", 5, 0, 0,     1, 0, 1);
        ex(59, "rxrst_b",     5, 0, 2'b10, 1, 0, 2);
        ex(62, "rxrst_b_end", 5, 0, 0,     1, 0, 2);
        ex(71, "fault",       7, 1, 0,     0, 1, 2);
        goto(33);
        pg = 1'b1;
        al = 2'b01;

        ex(75, "fault_exit", 0, 1, 0, 0, 0, 2);
        goto(74);
        enable = 1'b0;

        // Synchronous reset while port 1 is in P_RST
        ex(78, "pwr_wait3",  1, 1, 0,     0, 0, 0);
        ex(79, "rst_all3",   2, 1, 0,     0, 0, 0);
        ex(83, "tx_wait3",   3, 0, 0,     0, 0, 0);
        ex(84, "rx_wait3",   4, 0, 0,     0, 0, 0);
        ex(85, "align3",     5, 0, 0,     0, 0, 0);
        ex(86, "up0_3",      5, 0, 0,     1, 0, 0);
        ex(93, "rxrst3",     5, 0, 2'b10, 1, 0, 1);
        ex(95, "sync_reset", 0, 1, 0,     0, 0, 0);
        goto(77);
        enable = 1'b1;
        goto(94);
        rst    = 1'b1;
        enable = 1'b0;
        goto(96);
        rst = 1'b0;

        // TX done never arrives: restart every 16 TX_WAIT cycles
        ex(101, "pwr_wait4", 1, 1, 0, 0, 0, 0);
        ex(102, "rst_all4",  2, 1, 0, 0, 0, 0);
        for (int n = 1; n <= N; n++) begin
            ex(106 + 20 * (n - 1), "tx_to_wait",
               3, 0, 0, 0, 0, sat(n - 1));
            ex(122 + 20 * (n - 1), "tx_to_restart",
               2, 1, 0, 0, 0, sat(n));
        end
        ex(106 + 20 * N, "tx_to_last", 3, 0, 0, 0, 0, sat(N));
        ex(5271, "disable", 0, 1, 0, 0, 0, 255);
        goto(100);
        enable = 1'b1;
        pg     = 1'b1;
        txd    = 2'b00;
        rxd    = 2'b00;
        al     = 2'b00;
        goto(5270);
        enable = 1'b0;

        goto(5276);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d changes outstanding, want 0",
                     q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
